imem_loader: RTL and testbench

- Encoder-side counterpart of the instruction decoder. Accepts symbolic instruction requests (op, register fields, immediate) over a valid/ready handshake.
- Packs each request into a 32-bit MIPS word and writes it into instruction memory through a simple write port.
- Used by the bench and boot path to load programs into instruction memory before the core runs.

---
 rtl/imem_loader.sv | 171 +++++++++++++++++
 tb/tb_imem_loader.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: packs symbolic instruction requests (op, rs, rt, rd, imm)
// into 32-bit MIPS words and writes them into instruction memory, one word per
// accepted request, starting at BASE_ADDR for each load session.
//
// Optional build macro IMEM_LOADER_NOP_PAD_EN: when defined, a single NOP
// (0x00000000) is appended after the last word if there is room left.
//
// state | meaning
// IDLE  | waiting for start; no requests accepted
// LOAD  | accepting requests; after the last one, waits for its write to land
// FLUSH | writes the trailing NOP pad (macro builds only)
// DONE  | one-cycle done pulse, then back to IDLE
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_full,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

`ifdef IMEM_LOADER_NOP_PAD_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_FLUSH = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd3} state_t;
`endif

    state_t            state, next_state;
    logic [ADDR_W-1:0] ptr;
    logic              last_seen;
    logic              not_full;
    logic              hs;
    logic              illegal;
    logic [31:0]       enc_word;

    assign not_full = (count < DEPTH_C);
    assign hs       = req_valid && req_ready;
    assign illegal  = (req_op == 3'd7);

    // Next-state logic and state-decoded handshake/status outputs.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_LOAD;
            end
            S_LOAD: begin
                busy      = 1'b1;
                // Once the last request is taken, stop accepting and let its write land.
                req_ready = not_full && !last_seen;
                if (last_seen) begin
`ifdef IMEM_LOADER_NOP_PAD_EN
                    next_state = S_FLUSH;
`else
                    next_state = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_NOP_PAD_EN
            S_FLUSH: begin
                busy       = 1'b1;
                next_state = S_DONE;
            end
`endif
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Instruction encoder: R-type for ADD/AND/OR, I-type for the rest.
    always_comb begin
        enc_word = 32'h0;
        case (req_op)
            3'd0:    enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100000};
            3'd1:    enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100100};
            3'd2:    enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100101};
            3'd3:    enc_word = {6'b100011, req_rs, req_rt, req_imm};
            3'd4:    enc_word = {6'b101011, req_rs, req_rt, req_imm};
            3'd5:    enc_word = {6'b001000, req_rs, req_rt, req_imm};
            3'd6:    enc_word = {6'b001100, req_rs, req_rt, req_imm};
            default: enc_word = 32'h0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Write port, pointer, count and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we     <= 1'b0;
            imem_addr   <= BASE_C;
            imem_wdata  <= 32'h0;
            ptr         <= BASE_C;
            count       <= '0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
            last_seen   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr         <= BASE_C;
                        count       <= '0;
                        err_illegal <= 1'b0;
                        err_full    <= 1'b0;
                        last_seen   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        if (illegal) begin
                            err_illegal <= 1'b1;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_addr  <= ptr;
                            imem_wdata <= enc_word;
                            ptr        <= ptr + 1'b1;
                            count      <= count + 1'b1;
                        end
                        if (req_last) last_seen <= 1'b1;
                    end
                    if (req_valid && !not_full) err_full <= 1'b1;
                end
`ifdef IMEM_LOADER_NOP_PAD_EN
                S_FLUSH: begin
                    if (not_full) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ptr;
                        imem_wdata <= 32'h0;
                        ptr        <= ptr + 1'b1;
                        count      <= count + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default instance (DEPTH=256, BASE_ADDR=0)
// and a small instance (DEPTH=4, BASE_ADDR=8) for the full-memory case.
module tb_imem_loader;

`ifdef IMEM_LOADER_NOP_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, req_valid, req_last;
    logic [2:0]  req_op;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [15:0] req_imm;

    logic        req_ready, imem_we, busy, done, err_illegal, err_full;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  count;

    logic        f_req_ready, f_imem_we, f_busy, f_done, f_err_illegal, f_err_full;
    logic [7:0]  f_imem_addr;
    logic [31:0] f_imem_wdata;
    logic [8:0]  f_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {int c; logic [7:0] a; logic [31:0] d;} wr_t;
    wr_t wq[$];
    wr_t fq[$];
    int  done_c[$];
    int  fdone_n = 0;

    imem_loader dut (
        .clk(clk), .rst(rst), .start(start), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
        .req_last(req_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err_illegal(err_illegal), .err_full(err_full), .count(count)
    );

    imem_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(8)) dut_f (
        .clk(clk), .rst(rst), .start(start), .req_valid(req_valid), .req_ready(f_req_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
        .req_last(req_last), .imem_we(f_imem_we), .imem_addr(f_imem_addr), .imem_wdata(f_imem_wdata),
        .busy(f_busy), .done(f_done), .err_illegal(f_err_illegal), .err_full(f_err_full), .count(f_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record writes and done pulses mid-cycle.
    always @(negedge clk) begin
        wr_t w;
        if (imem_we) begin
            w.c = cyc; w.a = imem_addr; w.d = imem_wdata;
            wq.push_back(w);
        end
        if (f_imem_we) begin
            w.c = cyc; w.a = f_imem_addr; w.d = f_imem_wdata;
            fq.push_back(w);
        end
        if (done) done_c.push_back(cyc);
        if (f_done) fdone_n++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic idle_req();
        req_valid = 1'b0; req_last = 1'b0; req_op = 3'd0;
        req_rs = 5'd0; req_rt = 5'd0; req_rd = 5'd0; req_imm = 16'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; idle_req();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wq.delete(); fq.delete(); done_c.delete(); fdone_n = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Present a request and hold it until accepted; leaves req_valid asserted.
    task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic last);
        int n = 0;
        req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm; req_last = last;
        req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL send_accept: req_ready=%b expected 1 within 20 cycles", req_ready);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({req_ready, imem_we, busy, done, err_illegal, err_full} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {req_ready, imem_we, busy, done, err_illegal, err_full});
        end
        checks++;
        if (imem_addr !== 8'd0 || imem_wdata !== 32'h0 || count !== 9'd0) begin
            errors++;
            $display("FAIL reset_values: addr=%h wdata=%h count=%0d expected 00 00000000 0",
                     imem_addr, imem_wdata, count);
        end
        checks++;
        if (f_imem_addr !== 8'd8) begin
            errors++;
            $display("FAIL reset_base_addr: got %h expected 08", f_imem_addr);
        end
    endtask

    task automatic test_single();
        do_reset();
        pulse_start();
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
        idle_req();
        wait_cycles(6);
        checks++;
        if (wq.size() != 1 + PAD) begin
            errors++;
            $display("FAIL single_nwrites: got %0d expected %0d", wq.size(), 1 + PAD);
        end
        checks++;
        if (wq.size() < 1 || wq[0].a !== 8'd0 || wq[0].d !== 32'h00221820) begin
            errors++;
            $display("FAIL single_write: got %h@%h expected 00221820@00",
                     (wq.size() > 0) ? wq[0].d : 32'hx, (wq.size() > 0) ? wq[0].a : 8'hx);
        end
        checks++;
        if (done_c.size() != 1 || wq.size() < 1 || done_c[0] != wq[0].c + 1 + PAD) begin
            errors++;
            $display("FAIL single_done_timing: done pulses=%0d at=%0d expected 1 at write+%0d",
                     done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, 1 + PAD);
        end
`ifdef IMEM_LOADER_NOP_PAD_EN
        checks++;
        if (wq.size() < 2 || wq[1].a !== 8'd1 || wq[1].d !== 32'h0) begin
            errors++;
            $display("FAIL nop_pad_write: got %h@%h expected 00000000@01",
                     (wq.size() > 1) ? wq[1].d : 32'hx, (wq.size() > 1) ? wq[1].a : 8'hx);
        end
`endif
        checks++;
        if (count !== 9'(1 + PAD) || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_count: count=%0d busy=%b expected %0d 0", count, busy, 1 + PAD);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ed [4];
        ed[0] = 32'h8FA80004; ed[1] = 32'hAC850010; ed[2] = 32'h2009FFFF; ed[3] = 32'h306300FF;
        do_reset();
        pulse_start();
        send(3'd3, 5'd29, 5'd8, 5'd31, 16'h0004, 1'b0);
        send(3'd4, 5'd4,  5'd5, 5'd31, 16'h0010, 1'b0);
        send(3'd5, 5'd0,  5'd9, 5'd31, 16'hFFFF, 1'b0);
        send(3'd6, 5'd3,  5'd3, 5'd31, 16'h00FF, 1'b1);
        idle_req();
        wait_cycles(8);
        checks++;
        if (wq.size() != 4 + PAD) begin
            errors++;
            $display("FAIL b2b_nwrites: got %0d expected %0d", wq.size(), 4 + PAD);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wq.size() <= i || wq[i].a !== 8'(i) || wq[i].d !== ed[i] || wq[i].c != wq[0].c + i) begin
                errors++;
                $display("FAIL b2b_write%0d: got %h@%h cyc+%0d expected %h@%h cyc+%0d", i,
                         (wq.size() > i) ? wq[i].d : 32'hx, (wq.size() > i) ? wq[i].a : 8'hx,
                         (wq.size() > i) ? wq[i].c - wq[0].c : -1, ed[i], 8'(i), i);
            end
        end
        checks++;
        if (count !== 9'(4 + PAD)) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected %0d", count, 4 + PAD);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        pulse_start();
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'hFFFF, 1'b0);
        send(3'd7, 5'd7, 5'd7, 5'd7, 16'h1234, 1'b0);
        send(3'd0, 5'd4, 5'd5, 5'd6, 16'h0000, 1'b1);
        idle_req();
        wait_cycles(8);
        checks++;
        if (wq.size() != 2 + PAD) begin
            errors++;
            $display("FAIL illegal_nwrites: got %0d expected %0d", wq.size(), 2 + PAD);
        end
        checks++;
        if (wq.size() < 2 || wq[0].a !== 8'd0 || wq[0].d !== 32'h00221820 ||
            wq[1].a !== 8'd1 || wq[1].d !== 32'h00853020) begin
            errors++;
            $display("FAIL illegal_writes: got %h@%h %h@%h expected 00221820@00 00853020@01",
                     (wq.size() > 0) ? wq[0].d : 32'hx, (wq.size() > 0) ? wq[0].a : 8'hx,
                     (wq.size() > 1) ? wq[1].d : 32'hx, (wq.size() > 1) ? wq[1].a : 8'hx);
        end
        checks++;
        if (err_illegal !== 1'b1 || count !== 9'(2 + PAD)) begin
            errors++;
            $display("FAIL illegal_flag: err_illegal=%b count=%0d expected 1 %0d",
                     err_illegal, count, 2 + PAD);
        end
        pulse_start();
        checks++;
        if (err_illegal !== 1'b0 || count !== 9'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL illegal_clear: err_illegal=%b count=%0d busy=%b expected 0 0 1",
                     err_illegal, count, busy);
        end
        // An illegal op carrying last still closes the session.
        done_c.delete();
        send(3'd7, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1);
        idle_req();
        wait_cycles(6);
        checks++;
        if (done_c.size() != 1 || busy !== 1'b0 || err_illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_last_done: done pulses=%0d busy=%b err=%b expected 1 0 1",
                     done_c.size(), busy, err_illegal);
        end
    endtask

    task automatic test_full();
        do_reset();
        pulse_start();
        for (int i = 0; i < 4; i++) send(3'd0, 5'd1, 5'd2, 5'(i + 10), 16'h0, 1'b0);
        // Requests five and six: held valid but never accepted by the small instance.
        req_rd = 5'd20;
        wait_cycles(2);
        req_rd = 5'd21;
        wait_cycles(2);
        checks++;
        if (f_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b expected 0", f_req_ready);
        end
        idle_req();
        wait_cycles(4);
        checks++;
        if (fq.size() != 4) begin
            errors++;
            $display("FAIL full_nwrites: got %0d expected 4", fq.size());
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            e = {6'b0, 5'd1, 5'd2, 5'(i + 10), 5'b0, 6'b100000};
            checks++;
            if (fq.size() <= i || fq[i].a !== 8'(8 + i) || fq[i].d !== e) begin
                errors++;
                $display("FAIL full_write%0d: got %h@%h expected %h@%h", i,
                         (fq.size() > i) ? fq[i].d : 32'hx, (fq.size() > i) ? fq[i].a : 8'hx,
                         e, 8'(8 + i));
            end
        end
        checks++;
        if (f_err_full !== 1'b1 || f_count !== 9'd4 || fdone_n != 0 || f_busy !== 1'b1 ||
            f_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state: err_full=%b count=%0d done_pulses=%0d busy=%b ready=%b expected 1 4 0 1 0",
                     f_err_full, f_count, fdone_n, f_busy, f_req_ready);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_start();
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        // Next request stays valid while rst is asserted in this cycle.
        req_rd = 5'd9;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({imem_we, busy, done, req_ready, err_illegal, err_full} !== 6'b0) begin
            errors++;
            $display("FAIL rst_mid_flags: we,busy,done,ready,ill,full=%b expected 000000",
                     {imem_we, busy, done, req_ready, err_illegal, err_full});
        end
        checks++;
        if (imem_addr !== 8'd0 || imem_wdata !== 32'h0 || count !== 9'd0) begin
            errors++;
            $display("FAIL rst_mid_values: addr=%h wdata=%h count=%0d expected 00 00000000 0",
                     imem_addr, imem_wdata, count);
        end
        rst = 1'b0;
        wait_cycles(1);
        checks++;
        if (imem_we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: imem_we=%b busy=%b expected 0 0", imem_we, busy);
        end
        idle_req();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_illegal();
        test_full();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
